// File: rtl/brom_responder.sv
// brom_responder: instruction-memory end of the core fetch interface.
// A byte-serial loader fills the word array while the core is held in reset.
// After that, fetches are served in order with a fixed LATENCY and no backpressure.
module brom_responder #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [XLEN-1:0] req_addr,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    input  logic            ld_valid,
    input  logic [7:0]      ld_byte,
    input  logic            ld_last,
    output logic            ld_ready,
    output logic            ld_ovf,
    output logic            core_hold
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = XLEN / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]      state;
    logic [AW:0]     wptr;
    logic [BW-1:0]   byte_cnt;
    logic [XLEN-1:0] buffer;
    logic [XLEN-1:0] word_next;
    logic [XLEN-1:0] mem [DEPTH];

    logic ld_take;
    logic arr_full;
    logic word_done;
    logic mem_we;
    logic req_take;
    logic addr_ok;

    // Response pipeline: index 0 holds the array read, index LATENCY-1 drives the outputs.
    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] err_p;
    logic [XLEN-1:0]    data_p [LATENCY];

    assign ld_ready  = (state == S_LOAD);
    assign req_ready = (state == S_RUN);
    assign core_hold = (state != S_RUN);

    assign ld_take   = ld_valid & ld_ready;
    assign arr_full  = (wptr == (AW+1)'(DEPTH));
    assign word_done = (byte_cnt == BW'(NB - 1));
    // A word is committed when it fills up or when the image ends mid-word;
    // bytes arriving with the array full are dropped.
    assign mem_we    = ~reset & ld_take & ~arr_full & (word_done | ld_last);

    assign req_take  = req_valid & req_ready;
    // Full-width compare so any nonzero bit above AW flags the address as out of range.
    assign addr_ok   = (req_addr < XLEN'(DEPTH));

    assign rsp_valid = vld_p[LATENCY-1];
    assign rsp_err   = err_p[LATENCY-1];
    assign rsp_data  = data_p[LATENCY-1];

    // Merge the incoming loader byte into the partially assembled little-endian word.
    always_comb begin
        word_next = buffer;
        word_next[8*byte_cnt +: 8] = ld_byte;
    end

    // Load sequencing and LOAD -> FLUSH -> RUN state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_LOAD;
            wptr     <= '0;
            byte_cnt <= '0;
            buffer   <= '0;
            ld_ovf   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (ld_take) begin
                        if (arr_full) begin
                            ld_ovf <= 1'b1;
                        end else if (word_done | ld_last) begin
                            wptr     <= wptr + 1'b1;
                            byte_cnt <= '0;
                            buffer   <= '0;
                        end else begin
                            buffer   <= word_next;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                        if (ld_last) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: state <= S_RUN;
                S_RUN:   state <= S_RUN;
                default: state <= S_LOAD;
            endcase
        end
    end

    // Array write port; contents survive reset and are simply overwritten by the next load.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr[AW-1:0]] <= word_next;
        end
    end

    // Fetch pipeline: read on acceptance, then delay to LATENCY; data holds when no valid passes.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
            err_p <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= req_take;
            if (req_take) begin
                data_p[0] <= addr_ok ? mem[req_addr[AW-1:0]] : '0;
                err_p[0]  <= ~addr_ok;
            end
            for (int k = 1; k < LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1]) begin
                    data_p[k] <= data_p[k-1];
                    err_p[k]  <= err_p[k-1];
                end
            end
        end
    end

endmodule
